mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory-side bus between the core's instruction port (ibus, from fetch) and data port (dbus, from the memory stage).
- Sits between the core and the memory/cache interconnect.
- Grants one single-beat transaction at a time, forwards it unchanged, and routes the response back to the owner.
- Fixed priority: dbus over ibus. The memory-stage access is older and stalls the pipeline, so ibus cannot starve.

Parameters:
ADDR_W, 64, address width of all three buses
DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
i_valid  input  1  ibus request valid; held until i_data_ok
i_addr  input  ADDR_W  ibus fetch address
i_addr_ok  output  1  ibus request accepted
i_data_ok  output  1  ibus read data valid
i_data  output  DATA_W  ibus read data
d_valid  input  1  dbus request valid; held until d_data_ok
d_addr  input  ADDR_W  dbus address
d_size  input  3  log2 access bytes
d_strobe  input  DATA_W/8  byte write enables; all-zero means read
d_wdata  input  DATA_W  dbus write data
d_addr_ok  output  1  dbus request accepted
d_data_ok  output  1  dbus response valid
d_rdata  output  DATA_W  dbus read data
m_valid  output  1  memory request valid
m_is_write  output  1  1 = write
m_size  output  3  log2 access bytes
m_addr  output  ADDR_W  memory address
m_strobe  output  DATA_W/8  write strobes
m_wdata  output  DATA_W  write data
m_ready  input  1  memory beat complete
m_last  input  1  final beat; single-beat, so expected equal to m_ready
m_rdata  input  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, BUSY. Registered state: owner (0 = ibus, 1 = dbus) and latched request fields (addr, size, strobe, wdata, is_write).
- Reset (reset=0, async):
  - FSM → IDLE; owner → 0; all latched fields → 0.
  - m_valid, all *_addr_ok, all *_data_ok → 0 immediately.
  - Any m_ready seen in the same cycle is ignored.
- IDLE:
  - d_valid=1: latch dbus fields; is_write = |d_strobe; owner=1; → BUSY.
  - Else if i_valid=1: latch i_addr, size=3, strobe=0, wdata=0, is_write=0; owner=0; → BUSY.
  - Both valid in the same cycle: dbus wins; ibus is served on a later grant.
  - m_valid=0 throughout IDLE.
- BUSY:
  - m_valid=1; m_* driven only from latched registers, so they stay stable even if requester inputs change.
  - On m_ready & m_last: the owner's addr_ok and data_ok pulse high combinationally in that cycle, with data = m_rdata. The non-owner sees 0. FSM → IDLE.
  - m_ready with m_last=0 is not expected for single-beat traffic; the transaction continues and no response is issued.
- Latency:
  - Request at cycle N is granted at the N edge; m_valid is high in cycle N+1.
  - If m_ready is high in N+1, data_ok is in N+1 (minimum 1 cycle).
  - Mandatory IDLE cycle between transactions: the earliest next m_valid is 2 cycles after the previous m_valid's first cycle.
- Requester dropping valid mid-transaction: the transaction still completes; the data_ok pulse is still issued; no cancel.
- Read data: i_data/d_rdata = m_rdata when the matching data_ok=1, else 0.
- addr_ok == data_ok for both ports (no outstanding-address pipelining).
- Write response: d_data_ok pulses; d_rdata = m_rdata (don't-care to the core).

Optional Feature:
- Macro: MEM_BUS_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_i_grants (64), perf_d_grants (64) and perf_conflict_cycles (64).
  - perf_i_grants / perf_d_grants increment on each IDLE → BUSY grant for that port.
  - perf_conflict_cycles increments each cycle where i_valid=1 and the arbiter is not serving ibus (BUSY with owner=1, or IDLE with d_valid=1).
  - All three counters are reset to 0 by reset and wrap modulo 2^64.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. ibus read alone: i_valid=1, i_addr=0x8000_0000; m_ready=m_last=1 one cycle after m_valid with m_rdata=0x0000_0013 → m_addr=0x8000_0000, m_is_write=0, m_size=3; i_data_ok pulses 1 cycle with i_data=0x13; d_data_ok stays 0.
2. Simultaneous requests: i_valid=1 (0x8000_0004) and d_valid=1 (0x8000_1000, strobe=0xFF, wdata=0xDEAD_BEEF) in the same cycle → first m_valid carries the dbus write with m_is_write=1; after d_data_ok, one IDLE cycle; then ibus m_addr=0x8000_0004.
3. Memory stalls 5 cycles (m_ready=0) while d_addr changes every cycle → m_addr/m_wdata stay at the latched values; exactly one d_data_ok, in the m_ready cycle.
4. dbus read with d_size=2, strobe=0 at 0x8000_2004 → m_is_write=0, m_size=2, m_strobe=0; d_rdata=m_rdata=0x1234_5678_9ABC_DEF0 on d_data_ok.
5. Async reset asserted mid-BUSY (between clock edges) → m_valid falls immediately; a later m_ready produces no data_ok; after release, a pending i_valid is granted normally.
6. With MEM_BUS_ARBITER_PERF_EN, run scenario 2 → perf_d_grants=1, perf_i_grants=1, perf_conflict_cycles ≥ 2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-beat memory bus between the core's
// instruction port (ibus) and data port (dbus). dbus has fixed priority.
// The request is latched at grant and replayed on m_* until the beat completes.
// The response is routed combinationally back to the owning port.
// Optional performance counters: define MEM_BUS_ARBITER_PERF_EN.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_data,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_valid,
  output logic                m_is_write,
  output logic [2:0]          m_size,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic                m_last,
  input  logic [DATA_W-1:0]   m_rdata
`ifdef MEM_BUS_ARBITER_PERF_EN
  ,
  output logic [63:0]         perf_i_grants,
  output logic [63:0]         perf_d_grants,
  output logic [63:0]         perf_conflict_cycles
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
  logic [2:0]          lat_size, lat_size_nxt;
  logic [STRB_W-1:0]   lat_strobe, lat_strobe_nxt;
  logic [DATA_W-1:0]   lat_wdata, lat_wdata_nxt;
  logic                lat_is_write, lat_is_write_nxt;
  logic                beat_done;
  logic                grant_i, grant_d;

  // Only a final beat ends a transaction; a non-last ready beat is ignored.
  assign beat_done = m_ready & m_last;

  // State and latched request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      lat_addr     <= ADDR_W'(0);
      lat_size     <= 3'd0;
      lat_strobe   <= STRB_W'(0);
      lat_wdata    <= DATA_W'(0);
      lat_is_write <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      lat_addr     <= lat_addr_nxt;
      lat_size     <= lat_size_nxt;
      lat_strobe   <= lat_strobe_nxt;
      lat_wdata    <= lat_wdata_nxt;
      lat_is_write <= lat_is_write_nxt;
    end
  end

  // Next state: grant in IDLE (dbus first), release on final beat.
  always_comb begin
    state_nxt        = state;
    owner_nxt        = owner;
    lat_addr_nxt     = lat_addr;
    lat_size_nxt     = lat_size;
    lat_strobe_nxt   = lat_strobe;
    lat_wdata_nxt    = lat_wdata;
    lat_is_write_nxt = lat_is_write;
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    case (state)
      IDLE: begin
        if (d_valid) begin
          grant_d          = 1'b1;
          state_nxt        = BUSY;
          owner_nxt        = 1'b1;
          lat_addr_nxt     = d_addr;
          lat_size_nxt     = d_size;
          lat_strobe_nxt   = d_strobe;
          lat_wdata_nxt    = d_wdata;
          lat_is_write_nxt = |d_strobe;
        end else if (i_valid) begin
          grant_i          = 1'b1;
          state_nxt        = BUSY;
          owner_nxt        = 1'b0;
          lat_addr_nxt     = i_addr;
          lat_size_nxt     = 3'd3;
          lat_strobe_nxt   = STRB_W'(0);
          lat_wdata_nxt    = DATA_W'(0);
          lat_is_write_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (beat_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: memory side from latched fields, response routed to the owner.
  always_comb begin
    m_valid    = 1'b0;
    m_is_write = lat_is_write;
    m_size     = lat_size;
    m_addr     = lat_addr;
    m_strobe   = lat_strobe;
    m_wdata    = lat_wdata;
    i_addr_ok  = 1'b0;
    i_data_ok  = 1'b0;
    i_data     = DATA_W'(0);
    d_addr_ok  = 1'b0;
    d_data_ok  = 1'b0;
    d_rdata    = DATA_W'(0);
    if (state == BUSY) begin
      m_valid = 1'b1;
      if (beat_done) begin
        if (owner) begin
          d_addr_ok = 1'b1;
          d_data_ok = 1'b1;
          d_rdata   = m_rdata;
        end else begin
          i_addr_ok = 1'b1;
          i_data_ok = 1'b1;
          i_data    = m_rdata;
        end
      end
    end
  end

`ifdef MEM_BUS_ARBITER_PERF_EN
  logic conflict;

  // ibus is waiting while dbus holds or is taking the bus.
  assign conflict = i_valid & (((state == BUSY) & owner) | ((state == IDLE) & d_valid));

  // Grant and conflict counters, wrapping modulo 2^64.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_i_grants        <= 64'd0;
      perf_d_grants        <= 64'd0;
      perf_conflict_cycles <= 64'd0;
    end else begin
      if (grant_i)  perf_i_grants        <= perf_i_grants + 64'd1;
      if (grant_d)  perf_d_grants        <= perf_d_grants + 64'd1;
      if (conflict) perf_conflict_cycles <= perf_conflict_cycles + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: scenario tasks with a request scoreboard.
// Build with +define+MEM_BUS_ARBITER_PERF_EN to also check the perf counters.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic          i_addr_ok, i_data_ok;
  logic [DW-1:0] i_data;
  logic          d_valid;
  logic [AW-1:0] d_addr;
  logic [2:0]    d_size;
  logic [SW-1:0] d_strobe;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok, d_data_ok;
  logic [DW-1:0] d_rdata;
  logic          m_valid, m_is_write;
  logic [2:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_strobe;
  logic [DW-1:0] m_wdata;
  logic          m_ready, m_last;
  logic [DW-1:0] m_rdata;
`ifdef MEM_BUS_ARBITER_PERF_EN
  logic [63:0]   perf_i_grants, perf_d_grants, perf_conflict_cycles;
`endif

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_is_write(m_is_write), .m_size(m_size), .m_addr(m_addr),
    .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_last(m_last),
    .m_rdata(m_rdata)
`ifdef MEM_BUS_ARBITER_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [2:0]    size;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
  } req_t;

  req_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic req_t cap();
    req_t r;
    r.addr  = m_addr;
    r.wr    = m_is_write;
    r.size  = m_size;
    r.strb  = m_strobe;
    r.wdata = m_wdata;
    return r;
  endfunction

  function automatic req_t mk(input logic [AW-1:0] a, input logic w, input logic [2:0] s,
                              input logic [SW-1:0] st, input logic [DW-1:0] wd);
    req_t r;
    r.addr = a; r.wr = w; r.size = s; r.strb = st; r.wdata = wd;
    return r;
  endfunction

  // Waits (bounded) for m_valid; samples 1 time unit after the falling edge.
  task automatic wait_mvalid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (m_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL m_valid_timeout: m_valid stayed low for %0d cycles, required 1", budget);
    end
  endtask

  // Completes the beat at the next rising edge, then idles the memory inputs.
  task automatic end_beat();
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    m_last  = 1'b0;
    m_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b0; d_addr = '0; d_size = 3'd0; d_strobe = '0; d_wdata = '0;
    m_ready = 1'b0; m_last = 1'b0; m_rdata = '0;
    #1 reset = 1'b0;
    #11;
    vectors++;
    if ({m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000",
               {m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok});
    end
`ifdef MEM_BUS_ARBITER_PERF_EN
    vectors++;
    if ({perf_i_grants, perf_d_grants, perf_conflict_cycles} !== 192'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d/%0d/%0d required 0/0/0",
               perf_i_grants, perf_d_grants, perf_conflict_cycles);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ibus_read();
    req_t e, o;
    bit ok;
    @(negedge clk);
    i_valid = 1'b1; i_addr = 64'h8000_0000;
    sb.push_back(mk(64'h8000_0000, 1'b0, 3'd3, '0, '0));
    wait_mvalid(4, ok);
    e = sb.pop_front();
    if (ok) begin
      o = cap();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL ibus_req: got %h required %h", o, e);
      end
      m_ready = 1'b1; m_last = 1'b1; m_rdata = 64'h13;
      #1;
      vectors++;
      if ({i_addr_ok, i_data_ok, i_data, d_addr_ok, d_data_ok} !== {2'b11, 64'h13, 2'b00}) begin
        errors++;
        $display("FAIL ibus_resp: got ok=%b%b data=%h d_ok=%b%b required 11 13 00",
                 i_addr_ok, i_data_ok, i_data, d_addr_ok, d_data_ok);
      end
      i_valid = 1'b0;
      end_beat();
      @(negedge clk);
      #1;
      vectors++;
      if ({m_valid, i_data_ok, i_data} !== {2'b00, 64'h0}) begin
        errors++;
        $display("FAIL ibus_pulse_end: got valid=%b ok=%b data=%h required 0 0 0",
                 m_valid, i_data_ok, i_data);
      end
    end
  endtask

  task automatic test_simultaneous();
    req_t e, o;
    bit ok;
`ifdef MEM_BUS_ARBITER_PERF_EN
    logic [63:0] pi0, pd0, pc0;
    pi0 = perf_i_grants; pd0 = perf_d_grants; pc0 = perf_conflict_cycles;
`endif
    @(negedge clk);
    i_valid = 1'b1; i_addr = 64'h8000_0004;
    d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'd3;
    d_strobe = 8'hFF; d_wdata = 64'hDEAD_BEEF;
    sb.push_back(mk(64'h8000_1000, 1'b1, 3'd3, 8'hFF, 64'hDEAD_BEEF));
    sb.push_back(mk(64'h8000_0004, 1'b0, 3'd3, '0, '0));
    wait_mvalid(4, ok);
    e = sb.pop_front();
    if (ok) begin
      o = cap();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL sim_dbus_first: got %h required %h", o, e);
      end
      m_ready = 1'b1; m_last = 1'b1; m_rdata = 64'h77;
      #1;
      vectors++;
      if ({d_data_ok, d_addr_ok, i_data_ok, i_addr_ok} !== 4'b1100) begin
        errors++;
        $display("FAIL sim_dbus_resp: got d=%b%b i=%b%b required 11 00",
                 d_data_ok, d_addr_ok, i_data_ok, i_addr_ok);
      end
      d_valid = 1'b0; d_strobe = '0;
      end_beat();
      @(negedge clk);
      #1;
      vectors++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL sim_idle_gap: got m_valid=%b required 0", m_valid);
      end
    end
    wait_mvalid(3, ok);
    e = sb.pop_front();
    if (ok) begin
      o = cap();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL sim_ibus_second: got %h required %h", o, e);
      end
      m_ready = 1'b1; m_last = 1'b1; m_rdata = 64'h55;
      #1;
      vectors++;
      if ({i_data_ok, i_data, d_data_ok} !== {1'b1, 64'h55, 1'b0}) begin
        errors++;
        $display("FAIL sim_ibus_resp: got ok=%b data=%h d_ok=%b required 1 55 0",
                 i_data_ok, i_data, d_data_ok);
      end
      i_valid = 1'b0;
      end_beat();
    end
`ifdef MEM_BUS_ARBITER_PERF_EN
    @(negedge clk);
    vectors++;
    if ((perf_d_grants - pd0) !== 64'd1 || (perf_i_grants - pi0) !== 64'd1 ||
        (perf_conflict_cycles - pc0) < 64'd2) begin
      errors++;
      $display("FAIL perf_counts: got d=%0d i=%0d conflict=%0d required 1 1 >=2",
               perf_d_grants - pd0, perf_i_grants - pi0, perf_conflict_cycles - pc0);
    end
`endif
  endtask

  task automatic test_stall();
    req_t e, o;
    bit ok;
    int   pulses;
    @(negedge clk);
    d_valid = 1'b1; d_addr = 64'h8000_3000; d_size = 3'd2;
    d_strobe = 8'h0F; d_wdata = 64'hCAFE_F00D;
    sb.push_back(mk(64'h8000_3000, 1'b1, 3'd2, 8'h0F, 64'hCAFE_F00D));
    wait_mvalid(4, ok);
    e = sb.pop_front();
    if (ok) begin
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        d_addr  = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        @(negedge clk);
        #1;
        o = cap();
        if (d_data_ok === 1'b1) pulses++;
        vectors++;
        if (o !== e || m_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got valid=%b %h required 1 %h", c, m_valid, o, e);
        end
      end
      m_ready = 1'b1; m_last = 1'b1; m_rdata = 64'hABCD;
      #1;
      if (d_data_ok === 1'b1) pulses++;
      d_valid = 1'b0; d_strobe = '0;
      end_beat();
      @(negedge clk);
      #1;
      if (d_data_ok === 1'b1) pulses++;
      vectors++;
      if (pulses !== 1) begin
        errors++;
        $display("FAIL stall_one_pulse: got %0d d_data_ok pulses required 1", pulses);
      end
    end
  endtask

  task automatic test_dbus_read();
    req_t e, o;
    bit ok;
    @(negedge clk);
    d_valid = 1'b1; d_addr = 64'h8000_2004; d_size = 3'd2; d_strobe = '0; d_wdata = '0;
    sb.push_back(mk(64'h8000_2004, 1'b0, 3'd2, '0, '0));
    wait_mvalid(4, ok);
    e = sb.pop_front();
    if (ok) begin
      o = cap();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL dread_req: got %h required %h", o, e);
      end
      m_ready = 1'b1; m_last = 1'b1; m_rdata = 64'h1234_5678_9ABC_DEF0;
      #1;
      vectors++;
      if ({d_data_ok, d_rdata, i_data_ok} !== {1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0}) begin
        errors++;
        $display("FAIL dread_resp: got ok=%b data=%h i_ok=%b required 1 123456789abcdef0 0",
                 d_data_ok, d_rdata, i_data_ok);
      end
      d_valid = 1'b0;
      end_beat();
    end
  endtask

  task automatic test_async_reset();
    req_t e, o;
    bit ok;
    @(negedge clk);
    i_valid = 1'b1; i_addr = 64'h8000_0100;
    sb.push_back(mk(64'h8000_0100, 1'b0, 3'd3, '0, '0));
    wait_mvalid(4, ok);
    e = sb.pop_front();
    if (ok) begin
      o = cap();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_pre_req: got %h required %h", o, e);
      end
      #1 reset = 1'b0;
      #1;
      vectors++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mvalid_drop: got m_valid=%b required 0", m_valid);
      end
      m_ready = 1'b1; m_last = 1'b1; m_rdata = 64'h99;
      #1;
      vectors++;
      if ({i_data_ok, i_addr_ok, d_data_ok, d_addr_ok} !== 4'b0000) begin
        errors++;
        $display("FAIL rst_no_resp: got i=%b%b d=%b%b required 00 00",
                 i_data_ok, i_addr_ok, d_data_ok, d_addr_ok);
      end
      end_beat();
    end
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(mk(64'h8000_0100, 1'b0, 3'd3, '0, '0));
    wait_mvalid(4, ok);
    e = sb.pop_front();
    if (ok) begin
      o = cap();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_regrant: got %h required %h", o, e);
      end
      m_ready = 1'b1; m_last = 1'b1; m_rdata = 64'h2A;
      #1;
      vectors++;
      if ({i_data_ok, i_data} !== {1'b1, 64'h2A}) begin
        errors++;
        $display("FAIL rst_regrant_resp: got ok=%b data=%h required 1 2a", i_data_ok, i_data);
      end
      i_valid = 1'b0;
      end_beat();
    end
  endtask

  initial begin
    test_reset();
    test_ibus_read();
    test_simultaneous();
    test_stall();
    test_dbus_read();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
